// File: rtl/int_logic_pipe.sv
// int_logic_pipe: two-stage bitwise/shift/count unit with valid/ready handshakes.
// Stage S1 holds the accepted request; stage S2 holds the finished result.
// The only combinational input-to-output path is out_ready -> in_ready.
module int_logic_pipe #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_err
);

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_NAND    = 4'b0001,
    OP_OR      = 4'b0010,
    OP_NOR     = 4'b0011,
    OP_XOR     = 4'b0100,
    OP_XNOR    = 4'b0101,
    OP_NOTA    = 4'b0110,
    OP_PASSA   = 4'b0111,
    OP_SLL     = 4'b1000,
    OP_SRL     = 4'b1001,
    OP_SRA     = 4'b1010,
    OP_ROL     = 4'b1011,
    OP_ROR     = 4'b1100,
    OP_POPCNT  = 4'b1101,
    OP_CLZ     = 4'b1110,
    OP_ILLEGAL = 4'b1111
  } op_e;

  // Stage S1: captured request
  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_opa_q;
  logic [WIDTH-1:0] s1_opb_q;

  // Stage S2: registered result
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_out_q;
  logic             s2_zero_q;
  logic             s2_err_q;

  // Result computed from S1 contents
  logic [WIDTH-1:0]   res_d;
  logic               zero_d;
  logic               err_d;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rol_wide;
  logic [2*WIDTH-1:0] ror_wide;
  logic [SHW:0]       pop_cnt;
  logic [SHW:0]       clz_cnt;

  logic s2_adv;
  logic s1_adv;

  // Advance conditions: a stage moves when it is empty or its successor moves
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;

  // Only the low SHW bits of opb select the shift/rotate distance
  assign amt = s1_opb_q[SHW-1:0];

  // Rotates use a doubled copy of opa so an amount of zero naturally yields opa
  assign rol_wide = {s1_opa_q, s1_opa_q} << amt;
  assign ror_wide = {s1_opa_q, s1_opa_q} >> amt;

  // Population count of opa
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + (SHW+1)'(s1_opa_q[i]);
    end
  end

  // Leading-zero count of opa, scanning down from the MSB until the first one
  always_comb begin
    logic found;
    found   = 1'b0;
    clz_cnt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (s1_opa_q[i]) begin
          found = 1'b1;
        end else begin
          clz_cnt = clz_cnt + (SHW+1)'(1);
        end
      end
    end
  end

  // Opcode decode producing the result value and error flag
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (s1_op_q)
      OP_AND:     res_d = s1_opa_q & s1_opb_q;
      OP_NAND:    res_d = ~(s1_opa_q & s1_opb_q);
      OP_OR:      res_d = s1_opa_q | s1_opb_q;
      OP_NOR:     res_d = ~(s1_opa_q | s1_opb_q);
      OP_XOR:     res_d = s1_opa_q ^ s1_opb_q;
      OP_XNOR:    res_d = ~(s1_opa_q ^ s1_opb_q);
      OP_NOTA:    res_d = ~s1_opa_q;
      OP_PASSA:   res_d = s1_opa_q;
      OP_SLL:     res_d = s1_opa_q << amt;
      OP_SRL:     res_d = s1_opa_q >> amt;
      OP_SRA:     res_d = $signed(s1_opa_q) >>> amt;
      OP_ROL:     res_d = rol_wide[2*WIDTH-1:WIDTH];
      OP_ROR:     res_d = ror_wide[WIDTH-1:0];
      OP_POPCNT:  res_d = WIDTH'(pop_cnt);
      OP_CLZ:     res_d = WIDTH'(clz_cnt);
      OP_ILLEGAL: begin
        res_d = '0;
        err_d = 1'b1;
      end
      default: begin
        res_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  assign zero_d = (res_d == '0);

  // S1 register: capture a request whenever the stage can advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_opa_q   <= '0;
      s1_opb_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q  <= op_e'(operation);
        s1_opa_q <= opa;
        s1_opb_q <= opb;
      end
    end
  end

  // S2 register: take the computed result when the consumer frees the slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_out_q  <= res_d;
        s2_zero_q <= zero_d;
        s2_err_q  <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_int_logic_pipe.sv
// tb_int_logic_pipe: scoreboard bench for int_logic_pipe (WIDTH=64).
module tb_int_logic_pipe;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_err;

  typedef struct {
    logic [63:0] val;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sbQueue[$];
  exp_t monEntry;
  int   errorCount = 0;
  int   checkCount = 0;
  logic randomReady = 1'b0;
  logic holdPending = 1'b0;
  logic [65:0] heldWord;

  int_logic_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .operation(operation),
    .opa(opa),
    .opb(opb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .out_zero(out_zero),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Independent bit-level reference model
  function automatic exp_t modelOp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t r;
    int amt;
    int k;
    r.val = '0;
    r.err = 1'b0;
    amt = int'(b[5:0]);
    case (op)
      4'd0:  r.val = a & b;
      4'd1:  r.val = ~(a & b);
      4'd2:  r.val = a | b;
      4'd3:  r.val = ~(a | b);
      4'd4:  r.val = a ^ b;
      4'd5:  r.val = ~(a ^ b);
      4'd6:  r.val = ~a;
      4'd7:  r.val = a;
      4'd8:  for (int i = 0; i < 64; i++) r.val[i] = (i >= amt) ? a[i-amt] : 1'b0;
      4'd9:  for (int i = 0; i < 64; i++) r.val[i] = (i + amt < 64) ? a[i+amt] : 1'b0;
      4'd10: for (int i = 0; i < 64; i++) r.val[i] = (i + amt < 64) ? a[i+amt] : a[63];
      4'd11: for (int i = 0; i < 64; i++) r.val[(i+amt)%64] = a[i];
      4'd12: for (int i = 0; i < 64; i++) r.val[i] = a[(i+amt)%64];
      4'd13: r.val = 64'($countones(a));
      4'd14: begin
        k = 0;
        while (k < 64 && a[63-k] == 1'b0) k++;
        r.val = 64'(k);
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.val == 64'd0);
    return r;
  endfunction

  // Output monitor: pops the scoreboard on each output transfer and checks stalls hold
  always @(negedge clk) begin
    if (!rst) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("holdValid", 128'(out_valid), 128'd1);
        checkOutput("holdData", 128'({out_err, out_zero, out}), 128'(heldWord));
      end
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spurious", 128'd1, 128'd0);
        end else begin
          monEntry = sbQueue.pop_front();
          checkOutput("out", 128'(out), 128'(monEntry.val));
          checkOutput("outZero", 128'(out_zero), 128'(monEntry.zero));
          checkOutput("outErr", 128'(out_err), 128'(monEntry.err));
        end
      end
      holdPending = out_valid && !out_ready;
      heldWord    = {out_err, out_zero, out};
    end
  end

  // Present one request and hold it until accepted; the expectation is queued on acceptance
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input exp_t e);
    logic accepted;
    accepted  = 1'b0;
    operation = op;
    opa       = a;
    opb       = b;
    in_valid  = 1'b1;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        sbQueue.push_back(e);
      end
      @(posedge clk);
      #1;
      if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!accepted) checkOutput("acceptTimeout", 128'd0, 128'd1);
  endtask

  function automatic exp_t mk(input logic [63:0] v, input logic z, input logic er);
    exp_t e;
    e.val  = v;
    e.zero = z;
    e.err  = er;
    return e;
  endfunction

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;

    rst       = 1'b0;
    in_valid  = 1'b0;
    operation = 4'd0;
    opa       = '0;
    opb       = '0;
    out_ready = 1'b1;

    #2;
    checkOutput("rstValid", 128'(out_valid), 128'd0);
    checkOutput("rstOut", 128'(out), 128'd0);
    checkOutput("rstZero", 128'(out_zero), 128'd0);
    checkOutput("rstErr", 128'(out_err), 128'd0);
    checkOutput("rstReady", 128'(in_ready), 128'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // AND with latency check: not valid one cycle after accept, valid the next
    applyStimulus(4'd0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, mk(64'h0F0F00000F0F0000, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat1", 128'(out_valid), 128'd0);
    @(negedge clk);
    checkOutput("lat2", 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed operations
    applyStimulus(4'd10, 64'h8000000000000000, 64'd4, mk(64'hF800000000000000, 1'b0, 1'b0));
    applyStimulus(4'd11, 64'h8000000000000001, 64'h41, mk(64'h0000000000000003, 1'b0, 1'b0));
    applyStimulus(4'd13, 64'hFF, 64'h0, mk(64'd8, 1'b0, 1'b0));
    applyStimulus(4'd14, 64'h0, 64'h0, mk(64'd64, 1'b0, 1'b0));
    applyStimulus(4'd14, 64'h1, 64'h0, mk(64'd63, 1'b0, 1'b0));
    applyStimulus(4'd4, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, mk(64'd0, 1'b1, 1'b0));
    applyStimulus(4'd15, 64'hDEADBEEFCAFEF00D, 64'h5555AAAA5555AAAA, mk(64'd0, 1'b1, 1'b1));
    applyStimulus(4'd2, 64'h00F0, 64'h0F00, mk(64'h0FF0, 1'b0, 1'b0));
    applyStimulus(4'd9, 64'hF0, 64'h104, mk(64'hF, 1'b0, 1'b0));
    applyStimulus(4'd8, 64'hA5A5A5A5A5A5A5A5, 64'h40, mk(64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0));
    applyStimulus(4'd12, 64'h1, 64'h1, mk(64'h8000000000000000, 1'b0, 1'b0));
    applyStimulus(4'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, mk(64'd0, 1'b1, 1'b0));
    applyStimulus(4'd6, 64'h00000000FFFFFFFF, 64'h0, mk(64'hFFFFFFFF00000000, 1'b0, 1'b0));
    idleCycles(4);

    // Backpressure: two requests fill the pipe, the third waits until out_ready returns
    out_ready = 1'b0;
    applyStimulus(4'd7, 64'h1111, 64'h0, mk(64'h1111, 1'b0, 1'b0));
    applyStimulus(4'd7, 64'h2222, 64'h0, mk(64'h2222, 1'b0, 1'b0));
    operation = 4'd7;
    opa       = 64'h3333;
    opb       = 64'h0;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("fullReady", 128'(in_ready), 128'd0);
      checkOutput("fullValid", 128'(out_valid), 128'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pushPop", 128'(in_ready), 128'd1);
    checkOutput("drain0", 128'(out_valid), 128'd1);
    sbQueue.push_back(mk(64'h3333, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain1", 128'(out_valid), 128'd1);
    @(negedge clk);
    checkOutput("drain2", 128'(out_valid), 128'd1);
    @(negedge clk);
    checkOutput("drain3", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;

    // Reset mid-stream with two requests in flight
    applyStimulus(4'd7, 64'hABCD, 64'h0, mk(64'hABCD, 1'b0, 1'b0));
    applyStimulus(4'd7, 64'hBCDE, 64'h0, mk(64'hBCDE, 1'b0, 1'b0));
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sbQueue.delete();
    checkOutput("midRstValid", 128'(out_valid), 128'd0);
    checkOutput("midRstOut", 128'(out), 128'd0);
    checkOutput("midRstZero", 128'(out_zero), 128'd0);
    checkOutput("midRstErr", 128'(out_err), 128'd0);
    checkOutput("midRstReady", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("readyAfterRst", 128'(in_ready), 128'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("noStale", 128'(out_valid), 128'd0);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure
    randomReady = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk);
        #1;
      end
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'd0;
        1: ra = 64'hFFFFFFFFFFFFFFFF;
        2: ra = 64'd1 << $urandom_range(0, 63);
        3: ra = 64'h8000000000000000 | ra;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) rb = ra;
      applyStimulus(rop, ra, rb, modelOp(rop, ra, rb));
    end
    randomReady = 1'b0;
    out_ready   = 1'b1;
    idleCycles(6);
    checkOutput("drained", 128'(sbQueue.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/int_logic_pipe.md
INT_LOGIC_PIPE -- requirements
Module: int_logic_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL be a power of two, 8..128.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 Port in_valid  input  1  operation request present.
REQ-006 Port in_ready  output  1  block accepts the request this cycle.
REQ-007 Port operation  input  4  opcode per REQ-013.
REQ-008 Port opa, opb  input  WIDTH each  operands.
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port out  output  WIDTH  result.
REQ-012 Port out_zero / out_err  output  1 each  result==0 / illegal opcode.

Function
REQ-013 Opcodes: 0000 AND; 0001 NAND; 0010 OR; 0011 NOR; 0100 XOR; 0101 XNOR; 0110 bitwise ~opa; 0111 pass opa; 1000 SLL; 1001 SRL; 1010 SRA; 1011 ROL; 1100 ROR; 1101 POPCNT(opa); 1110 CLZ(opa); 1111 illegal.
REQ-014 Shifts/rotates SHALL use amount opb[SHW-1:0] and ignore opb[WIDTH-1:SHW]; amount 0 returns opa.
REQ-015 SRA SHALL fill with opa[WIDTH-1]; SLL/SRL SHALL fill with 0.
REQ-016 POPCNT and CLZ results SHALL be zero-extended to WIDTH; CLZ(0) = WIDTH.
REQ-017 Illegal opcode SHALL produce out = 0, out_err = 1, out_zero = 1; all legal ops give out_err = 0.
REQ-018 Two-stage pipeline: stage S1 registers operation/opa/opb; stage S2 registers out/out_zero/out_err, computed from S1.
REQ-019 Handshake: transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
REQ-020 S2 advances when !s2_valid | out_ready; S1 advances when !s1_valid | S2 advances.
REQ-021 in_ready = !s1_valid | S2-advance (combinational from out_ready; no other combinational input-to-output path).
REQ-022 Latency: accepted request appears on out_valid exactly 2 cycles later with out_ready held 1.
REQ-023 Throughput: one result per cycle with out_ready held 1.
REQ-024 While out_valid=1 & out_ready=0, out/out_zero/out_err SHALL hold stable.
REQ-025 Capacity 2 in-flight requests; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-026 Simultaneous output pop and input push on a full pipe SHALL be accepted in the same cycle.
REQ-027 Inputs with in_valid=0 SHALL NOT alter any state.

Reset
REQ-028 rst=0 SHALL immediately clear s1_valid and s2_valid; out_valid=0, out=0, out_zero=0, out_err=0, in_ready=1 while in reset.
REQ-029 Reset mid-operation SHALL discard all in-flight requests; no result emitted after release.
REQ-030 First request accepted on the first rising edge after rst returns to 1.

Verification
REQ-031 Reset: drive rst=0 mid-stream -> out_valid=0, out=0, in_ready=1 same cycle; no stale result after release.
REQ-032 AND, WIDTH=64: opa=0xFFFF0000FFFF0000, opb=0x0F0F0F0F0F0F0F0F -> out=0x0F0F00000F0F0000, out_zero=0, out_valid 2 cycles after accept.
REQ-033 Shifts: SRA opa=0x8000000000000000, opb=4 -> 0xF800000000000000; ROL opa=0x8000000000000001, opb=0x41 -> 0x0000000000000003.
REQ-034 Count ops: POPCNT opa=0xFF -> 8; CLZ opa=0 -> 64; CLZ opa=1 -> 63; XOR opa=opb -> out=0, out_zero=1.
REQ-035 Backpressure: out_ready=0, issue 3 requests -> 2 accepted, in_ready=0, out held; out_ready=1 -> all 3 results in order, one per cycle.
REQ-036 Illegal opcode 1111 with any operands -> out=0, out_err=1, out_zero=1; next legal op -> out_err=0.
